// File: rtl/rom_responder.sv
// Instruction-memory slave for the CPU fetch port: returns ROM words after
// WAIT_STATES wait cycles, with a harness load port that has priority over fetches.
module rom_responder #(
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 12,
    parameter int WAIT_STATES = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_ready,
    output logic                  o_busy,
    input  logic                  i_ld_we,
    input  logic [ADDR_WIDTH-1:0] i_ld_addr,
    input  logic [DATA_WIDTH-1:0] i_ld_data
);
    localparam logic [2:0] WS_CNT = 3'(WAIT_STATES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DATA} state_t;

    state_t                state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  accept;

    // Contents survive reset; writes are blocked only while reset is asserted.
    always_ff @(posedge i_clk) begin
        if (i_rst && i_ld_we) mem[i_ld_addr] <= i_ld_data;
    end

    // Combinational read of the pre-edge array gives read-before-write ordering.
    assign rd_word = mem[(state_q == S_WAIT) ? addr_q : i_addr];
    assign accept  = (state_q != S_WAIT) && i_req && !i_ld_we;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        case (state_q)
            S_IDLE, S_DATA: begin
                if (accept) begin
                    addr_d = i_addr;
                    cnt_d  = WS_CNT;
                    if (WAIT_STATES > 0) begin
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_DATA;
                        data_d  = rd_word;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    state_d = S_DATA;
                    data_d  = rd_word;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        o_ready = (state_q == S_DATA);
        o_busy  = (state_q == S_WAIT);
        o_data  = data_q;
    end
endmodule

// File: tb/tb_rom_responder.sv
// Directed bench: three responders (0, 1 and 3 wait states) share clock, reset
// and load port; each has its own fetch port.
module tb_rom_responder;
    logic        clk = 0;
    logic        rst;
    logic        ld_we;
    logic [11:0] ld_addr;
    logic [15:0] ld_data;
    logic        req0, req1, req3;
    logic [11:0] addr0, addr1, addr3;
    logic [15:0] data0, data1, data3;
    logic        rdy0, rdy1, rdy3;
    logic        bsy0, bsy1, bsy3;
    int          n_eval = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    rom_responder #(.DATA_WIDTH(16), .ADDR_WIDTH(12), .WAIT_STATES(0)) u_ws0 (
        .i_clk(clk), .i_rst(rst), .i_req(req0), .i_addr(addr0),
        .o_data(data0), .o_ready(rdy0), .o_busy(bsy0),
        .i_ld_we(ld_we), .i_ld_addr(ld_addr), .i_ld_data(ld_data));
    rom_responder #(.DATA_WIDTH(16), .ADDR_WIDTH(12), .WAIT_STATES(1)) u_ws1 (
        .i_clk(clk), .i_rst(rst), .i_req(req1), .i_addr(addr1),
        .o_data(data1), .o_ready(rdy1), .o_busy(bsy1),
        .i_ld_we(ld_we), .i_ld_addr(ld_addr), .i_ld_data(ld_data));
    rom_responder #(.DATA_WIDTH(16), .ADDR_WIDTH(12), .WAIT_STATES(3)) u_ws3 (
        .i_clk(clk), .i_rst(rst), .i_req(req3), .i_addr(addr3),
        .o_data(data3), .o_ready(rdy3), .o_busy(bsy3),
        .i_ld_we(ld_we), .i_ld_addr(ld_addr), .i_ld_data(ld_data));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_eval++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [11:0] a, input logic [15:0] d);
        ld_we = 1; ld_addr = a; ld_data = d;
        step();
        ld_we = 0;
    endtask

    initial begin
        rst = 0; ld_we = 0; ld_addr = '0; ld_data = '0;
        req0 = 0; req1 = 0; req3 = 0; addr0 = '0; addr1 = '0; addr3 = '0;
        step(); step();
        chk("rst_ready", {29'd0, rdy0, rdy1, rdy3}, 32'd0);
        chk("rst_busy",  {29'd0, bsy0, bsy1, bsy3}, 32'd0);
        chk("rst_data1", 32'(data1), 32'h0);
        rst = 1;
        load(12'h000, 16'h1234);
        load(12'hFFF, 16'hBEEF);
        load(12'h010, 16'h0001);
        load(12'h005, 16'h5555);

        // one wait state: busy one cycle, ready one cycle, data held
        req1 = 1; addr1 = 12'h000;
        step();
        req1 = 0;
        chk("ws1_busy",  32'(bsy1), 32'd1);
        chk("ws1_nrdy",  32'(rdy1), 32'd0);
        step();
        chk("ws1_ready", 32'(rdy1), 32'd1);
        chk("ws1_data",  32'(data1), 32'h1234);
        chk("ws1_nbusy", 32'(bsy1), 32'd0);
        step();
        chk("ws1_drop",  32'(rdy1), 32'd0);
        chk("ws1_hold",  32'(data1), 32'h1234);

        // zero wait states, back-to-back across the top address
        req0 = 1; addr0 = 12'h000;
        step();
        chk("ws0_r0", 32'(rdy0), 32'd1);
        chk("ws0_d0", 32'(data0), 32'h1234);
        addr0 = 12'hFFF;
        step();
        chk("ws0_r1", 32'(rdy0), 32'd1);
        chk("ws0_d1", 32'(data0), 32'hBEEF);
        addr0 = 12'h000;
        step();
        chk("ws0_r2", 32'(rdy0), 32'd1);
        chk("ws0_d2", 32'(data0), 32'h1234);
        req0 = 0;
        step();
        chk("ws0_idle", 32'(rdy0), 32'd0);

        // three wait states, request collides with a load write
        req3 = 1; addr3 = 12'h010; ld_we = 1; ld_addr = 12'h020; ld_data = 16'h7777;
        step();
        ld_we = 0;
        chk("defer_busy", 32'(bsy3), 32'd0);
        step();
        req3 = 0;
        chk("defer_acc", 32'(bsy3), 32'd1);
        step(); step();
        chk("defer_nrdy", 32'(rdy3), 32'd0);
        step();
        chk("defer_rdy",  32'(rdy3), 32'd1);
        chk("defer_data", 32'(data3), 32'h0001);

        // load during first wait cycle is visible
        step();
        req3 = 1; addr3 = 12'h010;
        step();
        req3 = 0;
        load(12'h010, 16'h0002);
        step(); step();
        chk("wr_early_rdy",  32'(rdy3), 32'd1);
        chk("wr_early_data", 32'(data3), 32'h0002);

        // load on the data-load edge returns the old word
        step();
        req3 = 1; addr3 = 12'h010;
        step();
        req3 = 0;
        step(); step();
        load(12'h010, 16'h0003);
        chk("wr_late_rdy",  32'(rdy3), 32'd1);
        chk("wr_late_data", 32'(data3), 32'h0002);
        req0 = 1; addr0 = 12'h010;
        step();
        req0 = 0;
        chk("wr_late_mem", 32'(data0), 32'h0003);

        // reset mid-wait drops the request
        step();
        req3 = 1; addr3 = 12'h000;
        step();
        req3 = 0;
        step();
        rst = 0;
        step();
        chk("midrst_rdy",  32'(rdy3), 32'd0);
        chk("midrst_data", 32'(data3), 32'h0);
        chk("midrst_busy", 32'(bsy3), 32'd0);
        rst = 1;
        step(); step(); step();
        chk("midrst_nopulse", 32'(rdy3), 32'd0);
        req3 = 1; addr3 = 12'h000;
        step();
        req3 = 0;
        step(); step(); step();
        chk("postrst_rdy",  32'(rdy3), 32'd1);
        chk("postrst_data", 32'(data3), 32'h1234);

        // load writes are ignored during reset
        rst = 0; ld_we = 1; ld_addr = 12'h005; ld_data = 16'hAAAA;
        step(); step();
        ld_we = 0; rst = 1;
        step();
        req0 = 1; addr0 = 12'h005;
        step();
        req0 = 0;
        chk("rstwr_rdy",  32'(rdy0), 32'd1);
        chk("rstwr_data", 32'(data0), 32'h5555);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
        $finish;
    end
endmodule
